fru_patch_ctrl: RTL and testbench

Parametrised field-replaceable-unit controller: generalises the per-signal filter into N independently configured channels, each armed by one of M trigger inputs from the SMU array. A configuration frame is shifted in serially on the system clock, committed atomically, and then applied to the controllable signal set. Per channel, the frame selects pass-through, force-constant, hold-last-value or invert. The block sits between the SMU trigger outputs and the controllable signal set of the patched IP.

---
 rtl/fru_patch_ctrl.sv | 139 +++++++++++++
 tb/tb_fru_patch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fru_patch_ctrl.sv
// Field-replaceable-unit patch controller: N channels, each armed by one of M sticky triggers,
// configured by a serially shifted, atomically committed frame. Define FRU_CFG_PARITY_EN for the parity-checked frame.
module fru_patch_ctrl #(
  parameter int M = 6,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] trig,
  input  logic [N-1:0] q_in,
  output logic [N-1:0] q_out,
  input  logic         BitStreamSerialIn,
  input  logic         BitStreamValid,
  input  logic         cfg_clr,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic [N-1:0] patch_active
);
  localparam int TW    = $clog2(M);
  localparam int CW    = TW + 4;
  localparam int ACT_W = N * CW;
`ifdef FRU_CFG_PARITY_EN
  localparam int CFG_WIDTH = ACT_W + 1;
`else
  localparam int CFG_WIDTH = ACT_W;
`endif
  localparam int CNT_W = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_WIDTH - 1);
  localparam logic [TW:0]      M_LIM    = (TW + 1)'(M);
  localparam int TL_EXT_W = 1 << TW;

  // The oldest frame bit is only needed on the committing cycle, where it comes from sh_shift.
  logic [CFG_WIDTH-2:0] sh_q, sh_d;
  logic [CFG_WIDTH-1:0] sh_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACT_W-1:0]     act_q, act_d;
  logic [M-1:0]         tl_q, tl_d;
  logic [N-1:0]         hr_q, hr_d;
  logic                 done_q, done_d;
  logic [N-1:0]         active;
  logic [TL_EXT_W-1:0]  tl_ext;
`ifdef FRU_CFG_PARITY_EN
  logic                 err_q, err_d;
`endif

  always_comb begin
    sh_shift = {sh_q, BitStreamSerialIn};
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    tl_d     = tl_q | trig;
    done_d   = 1'b0;
`ifdef FRU_CFG_PARITY_EN
    err_d    = 1'b0;
`endif
    if (cfg_clr) begin
      sh_d  = '0;
      cnt_d = '0;
      tl_d  = trig;
    end else if (BitStreamValid) begin
      sh_d = sh_shift[CFG_WIDTH-2:0];
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
`ifdef FRU_CFG_PARITY_EN
        if (^sh_shift) begin
          err_d = 1'b1;
        end else begin
          act_d  = sh_shift[CFG_WIDTH-1 -: ACT_W];
          tl_d   = trig;
          done_d = 1'b1;
        end
`else
        act_d  = sh_shift[CFG_WIDTH-1 -: ACT_W];
        tl_d   = trig;
        done_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    hr_d = (hr_q & active) | (q_in & ~active);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      act_q  <= '0;
      tl_q   <= '0;
      hr_q   <= '0;
      done_q <= 1'b0;
`ifdef FRU_CFG_PARITY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      tl_q   <= tl_d;
      hr_q   <= hr_d;
      done_q <= done_d;
`ifdef FRU_CFG_PARITY_EN
      err_q  <= err_d;
`endif
    end
  end

  // Zero-extend the latches so any TSEL value can index safely; out-of-range selects read 0.
  always_comb begin
    tl_ext         = '0;
    tl_ext[M-1:0]  = tl_q;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic          en;
    logic [1:0]    mode;
    logic          cst;
    logic [TW-1:0] tsel;

    assign en   = act_q[gi*CW + CW - 1];
    assign mode = act_q[gi*CW + CW - 2 -: 2];
    assign cst  = act_q[gi*CW + TW];
    assign tsel = act_q[gi*CW +: TW];

    assign active[gi] = en & ({1'b0, tsel} < M_LIM) & tl_ext[tsel];
    assign q_out[gi]  = !active[gi]   ? q_in[gi] :
                        (mode == 2'b01) ? cst :
                        (mode == 2'b10) ? hr_q[gi] :
                        (mode == 2'b11) ? ~q_in[gi] : q_in[gi];
  end

  assign patch_active = active;
  assign cfg_done     = done_q;
`ifdef FRU_CFG_PARITY_EN
  assign cfg_err      = err_q;
`else
  assign cfg_err      = 1'b0;
`endif
endmodule

// File: tb/tb_fru_patch_ctrl.sv
// Bench for fru_patch_ctrl (N=4, M=4): hand sequences, a vector table and random traffic,
// all checked against a queue-based behavioural model.
module tb_fru_patch_ctrl;
  localparam int N = 4;
  localparam int M = 4;
  localparam int CW = 6;
  localparam int ACT_W = 24;
`ifdef FRU_CFG_PARITY_EN
  localparam int FLEN = 25;
`else
  localparam int FLEN = 24;
`endif

  logic         clk;
  logic         rst;
  logic [M-1:0] trig;
  logic [N-1:0] q_in;
  logic [N-1:0] q_out;
  logic         BitStreamSerialIn;
  logic         BitStreamValid;
  logic         cfg_clr;
  logic         cfg_done;
  logic         cfg_err;
  logic [N-1:0] patch_active;

  fru_patch_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .trig(trig), .q_in(q_in), .q_out(q_out),
    .BitStreamSerialIn(BitStreamSerialIn), .BitStreamValid(BitStreamValid),
    .cfg_clr(cfg_clr), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .patch_active(patch_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [3:0] q_v;

  // Behavioural model: frame bits collected in a queue, decoded per channel on completion.
  bit       fbits[$];
  bit       m_en[N];
  bit [1:0] m_mode[N];
  bit       m_cst[N];
  int       m_tsel[N];
  bit       m_tl[M];
  bit       m_hr[N];
  bit       m_done, m_err;

  function automatic bit m_active(input int i);
    if (!m_en[i] || m_tsel[i] >= M) return 1'b0;
    return m_tl[m_tsel[i]];
  endfunction

  function automatic logic [3:0] m_pa();
    logic [3:0] r;
    for (int i = 0; i < N; i++) r[i] = m_active(i);
    return r;
  endfunction

  function automatic logic [3:0] m_qout(input logic [3:0] q);
    logic [3:0] r;
    for (int i = 0; i < N; i++) begin
      if (!m_active(i))          r[i] = q[i];
      else if (m_mode[i] == 2'd1) r[i] = m_cst[i];
      else if (m_mode[i] == 2'd2) r[i] = m_hr[i];
      else if (m_mode[i] == 2'd3) r[i] = ~q[i];
      else                        r[i] = q[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    fbits.delete();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_cst[i] = 0; m_tsel[i] = 0; m_hr[i] = 0;
    end
    for (int i = 0; i < M; i++) m_tl[i] = 0;
    m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] t, input logic [3:0] q, input bit b, input bit v, input bit c);
    bit act_prev[N];
    bit clear_tl;
    int ones;
    clear_tl = 0;
    for (int i = 0; i < N; i++) act_prev[i] = m_active(i);
    for (int i = 0; i < N; i++) if (!act_prev[i]) m_hr[i] = q[i];
    m_done = 0;
    m_err = 0;
    if (c) begin
      fbits.delete();
      clear_tl = 1;
    end else if (v) begin
      fbits.push_back(b);
      if (fbits.size() == FLEN) begin
        ones = 0;
        foreach (fbits[k]) ones += int'(fbits[k]);
        if (FLEN != ACT_W && (ones % 2) == 1) begin
          m_err = 1;
        end else begin
          // Frame position k carries field bit (ACT_W-1-k); channel i owns bits i*CW .. i*CW+5.
          for (int i = 0; i < N; i++) begin
            m_en[i]   = fbits[ACT_W-1-(i*CW+5)];
            m_mode[i] = {fbits[ACT_W-1-(i*CW+4)], fbits[ACT_W-1-(i*CW+3)]};
            m_cst[i]  = fbits[ACT_W-1-(i*CW+2)];
            m_tsel[i] = 2*int'(fbits[ACT_W-1-(i*CW+1)]) + int'(fbits[ACT_W-1-(i*CW)]);
          end
          m_done = 1;
          clear_tl = 1;
        end
        fbits.delete();
      end
    end
    for (int i = 0; i < M; i++) m_tl[i] = (clear_tl ? 1'b0 : m_tl[i]) | t[i];
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] t, input logic b, input logic v, input logic c);
    trig = t; BitStreamSerialIn = b; BitStreamValid = v; cfg_clr = c; q_in = q_v;
    @(posedge clk);
    model_step(t, q_v, b, v, c);
    #1;
    check("model_q_out", q_out, m_qout(q_v));
    check("model_patch_active", patch_active, m_pa());
    check("model_cfg_done", {3'b0, cfg_done}, {3'b0, m_done});
    check("model_cfg_err", {3'b0, cfg_err}, {3'b0, m_err});
    if (cfg_done) done_cnt++;
    if (cfg_err) err_cnt++;
  endtask

  function automatic logic [23:0] mk(input logic [5:0] c3, input logic [5:0] c2,
                                     input logic [5:0] c1, input logic [5:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic send_bits(input logic [23:0] f, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) cycle(4'b0, f[k], 1'b1, 1'b0);
  endtask

  task automatic send_tail(input logic [23:0] f, input bit bad);
`ifdef FRU_CFG_PARITY_EN
    cycle(4'b0, bad ? ~(^f) : ^f, 1'b1, 1'b0);
`else
    if (bad) $display("note: parity error requested in a build without parity");
`endif
  endtask

  task automatic send_frame(input logic [23:0] f, input bit bad);
    send_bits(f, 23, 0);
    send_tail(f, bad);
  endtask

  typedef struct {
    logic [3:0] trig;
    logic [3:0] q;
    logic [3:0] exp_q;
    logic [3:0] exp_pa;
  } vec_t;
  vec_t tbl[8];

  logic [23:0] fa, fb, fc, fd;

  initial begin
    // ch0 hold/TSEL0, ch1 invert/TSEL1, ch2 force-1/TSEL3, ch3 pass/TSEL2
    tbl[0] = '{4'b0000, 4'b0101, 4'b0101, 4'b0000};
    tbl[1] = '{4'b0001, 4'b1111, 4'b1111, 4'b0001};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tbl[3] = '{4'b0010, 4'b0000, 4'b0011, 4'b0011};
    tbl[4] = '{4'b0000, 4'b0110, 4'b0101, 4'b0011};
    tbl[5] = '{4'b1000, 4'b0110, 4'b0101, 4'b0111};
    tbl[6] = '{4'b0100, 4'b1001, 4'b1111, 4'b1111};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0111, 4'b1111};

    rst = 1'b0; trig = '0; BitStreamSerialIn = 1'b0; BitStreamValid = 1'b0; cfg_clr = 1'b0;
    q_v = 4'b1010; q_in = q_v;
    model_reset();
    #12;
    check("reset_q_out", q_out, 4'b1010);
    check("reset_patch_active", patch_active, 4'b0000);
    check("reset_cfg_done", {3'b0, cfg_done}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // Force mode
    q_v = 4'b0000;
    send_frame(mk(6'b0, 6'b101111, 6'b0, 6'b0), 1'b0);
    check("force_cfg_done", {3'b0, cfg_done}, 4'b0001);
    check("force_pa_before_trig", patch_active, 4'b0000);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    check("force_q_out", q_out, 4'b0100);
    check("force_patch_active", patch_active, 4'b0100);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    check("force_sticky", patch_active, 4'b0100);

    // Hold and invert
    send_frame(mk(6'b0, 6'b0, 6'b111001, 6'b110001), 1'b0);
    q_v = 4'b0001;
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    q_v = 4'b0010;
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    check("hold_inv_q_out", q_out, 4'b0001);
    check("hold_inv_patch_active", patch_active, 4'b0011);

    // Paused frame followed immediately by a second frame
    q_v = 4'b1000;
    fa = mk(6'b101100, 6'b0, 6'b0, 6'b0);
    fb = mk(6'b101000, 6'b0, 6'b0, 6'b0);
    done_cnt = 0;
    send_bits(fa, 23, 12);
    repeat (5) cycle(4'b0, 1'b1, 1'b0, 1'b0);
    send_bits(fa, 11, 0);
    send_tail(fa, 1'b0);
    send_frame(fb, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    check("b2b_done_pulses", 4'(done_cnt), 4'd2);
    check("b2b_second_wins", q_out, 4'b0000);
    check("b2b_patch_active", patch_active, 4'b1000);

    // cfg_clr mid-frame
    fc = mk(6'b0, 6'b0, 6'b101110, 6'b0);
    send_bits(fc, 23, 14);
    cycle(4'b0, 1'b1, 1'b1, 1'b1);
    check("clr_tl_cleared", patch_active, 4'b0000);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    check("clr_act_retained_pa", patch_active, 4'b1000);
    check("clr_act_retained_q", q_out, 4'b0000);
    done_cnt = 0;
    send_frame(fc, 1'b0);
    check("clr_single_commit", 4'(done_cnt), 4'd1);
    check("clr_commit_clears_tl", patch_active, 4'b0000);
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    check("clr_new_cfg_pa", patch_active, 4'b0010);
    check("clr_new_cfg_q", q_out, 4'b1010);

`ifdef FRU_CFG_PARITY_EN
    done_cnt = 0; err_cnt = 0;
    send_frame(mk(6'b101100, 6'b0, 6'b0, 6'b0), 1'b1);
    check("par_err_pulses", 4'(err_cnt), 4'd1);
    check("par_no_done", 4'(done_cnt), 4'd0);
    check("par_pa_kept", patch_active, 4'b0010);
    check("par_q_kept", q_out, 4'b1010);
`endif

    // Vector table
    fd = mk(6'b100010, 6'b101111, 6'b111001, 6'b110000);
    send_frame(fd, 1'b0);
    for (int r = 0; r < 8; r++) begin
      q_v = tbl[r].q;
      cycle(tbl[r].trig, 1'b0, 1'b0, 1'b0);
      check($sformatf("tbl%0d_q_out", r), q_out, tbl[r].exp_q);
      check($sformatf("tbl%0d_patch_active", r), patch_active, tbl[r].exp_pa);
    end

    // Asynchronous reset mid-frame
    repeat (7) cycle(4'b0, 1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_q_out", q_out, 4'b0000);
    check("async_rst_pa", patch_active, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_held_done", {3'b0, cfg_done}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    q_v = 4'($urandom);
    send_frame(fd, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] t;
      q_v = 4'($urandom);
      t = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      cycle(t, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
